muldiv_sequencer: RTL and testbench

Iterative RV32M multiply/divide unit with its own sequencing FSM. It sits beside the ALU in the EX stage. The ALU controller's decode steers M-extension instructions here instead of to the single-cycle ALU. The block holds the pipeline with `Stall` while it runs a fixed-latency shift-add multiply or restoring divide, then presents a one-cycle `Done` pulse with the result.

---
 rtl/muldiv_sequencer.sv | 175 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// sequenced by an IDLE/CALC/FIX/DONE FSM that stalls the pipeline while it runs.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic             Kill,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] Result,
    output logic             Done,
    output logic             Busy,
    output logic             Stall
);
    localparam int unsigned ACC_W = 2 * WIDTH + 1;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [2:0]         funct3_q, funct3_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               in_signed_a, in_signed_b, in_sign_a, in_sign_b;
    logic [WIDTH-1:0]   in_mag_a, in_mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [ACC_W-1:0]   mul_next;
    logic [ACC_W-1:0]   div_sh;
    logic [WIDTH:0]     div_diff;
    logic [ACC_W-1:0]   div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, fix_result;

    // Operand sign handling: MULHSU keeps B unsigned; the U ops ignore both signs.
    assign in_signed_a = Funct3[2] ? ~Funct3[0] : (Funct3[1:0] != 2'b11);
    assign in_signed_b = Funct3[2] ? ~Funct3[0] : ~Funct3[1];
    assign in_sign_a   = in_signed_a & SrcA[WIDTH-1];
    assign in_sign_b   = in_signed_b & SrcB[WIDTH-1];
    assign in_mag_a    = in_sign_a ? -SrcA : SrcA;
    assign in_mag_b    = in_sign_b ? -SrcB : SrcB;

    // One iteration step of each algorithm plus the FIX-stage sign correction.
    always_comb begin
        mul_sum  = acc_q[ACC_W-1:WIDTH] + {1'b0, mag_a_q};
        mul_next = acc_q[0] ? ({mul_sum, acc_q[WIDTH-1:0]} >> 1) : (acc_q >> 1);

        div_sh   = {acc_q[ACC_W-2:0], 1'b0};
        div_diff = div_sh[ACC_W-1:WIDTH] - {1'b0, mag_b_q};
        div_next = div_diff[WIDTH] ? {1'b0, div_sh[ACC_W-2:0]}
                                   : {1'b0, div_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};

        prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        if (dbz_q) begin
            quot_fix = '1;
            rem_fix  = sign_a_q ? -mag_a_q : mag_a_q;
        end else begin
            quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end

        case (funct3_q)
            3'b000:                 fix_result = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_result = quot_fix;
            default:                fix_result = rem_fix;
        endcase
    end

    // Next-state and register update logic.
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        dbz_d    = dbz_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        count_d  = count_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start && !Kill) begin
                    state_d  = S_CALC;
                    funct3_d = Funct3;
                    sign_a_d = in_sign_a;
                    sign_b_d = in_sign_b;
                    dbz_d    = Funct3[2] & (SrcB == '0);
                    mag_a_d  = in_mag_a;
                    mag_b_d  = in_mag_b;
                    count_d  = '0;
                    // Low half seeds the multiplier (multiply) or the dividend (divide).
                    acc_d    = {1'b0, {WIDTH{1'b0}}, (Funct3[2] ? in_mag_a : in_mag_b)};
                end
            end
            S_CALC: begin
                if (Kill) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = funct3_q[2] ? div_next : mul_next;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (Kill) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_DONE;
                    result_d = fix_result;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            funct3_q <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dbz_q    <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            count_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            dbz_q    <= dbz_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign Result = result_q;
    assign Done   = done_q;
    assign Busy   = busy_q;
    // Combinational so the request cycle itself is already held.
    assign Stall  = ((state_q == S_IDLE) & Start & ~Kill) | (state_q == S_CALC) | (state_q == S_FIX);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: table vectors, reference-model random ops, and
// hand-written kill / reset / back-to-back sequences, checked via a result scoreboard.
module tb_muldiv_sequencer;
    logic        clk, rst_n, Start, Kill;
    logic [2:0]  Funct3;
    logic [31:0] SrcA, SrcB, Result;
    logic        Done, Busy, Stall;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Kill(Kill), .Funct3(Funct3),
        .SrcA(SrcA), .SrcB(SrcB), .Result(Result), .Done(Done), .Busy(Busy), .Stall(Stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 14;
    localparam int LAT = 33;
    vec_t        vecs[NV];
    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          n_vec, n_err;
    bit          got_done, prev_done;
    logic [31:0] last_result;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and score any completed operation.
    task automatic cycle();
        @(negedge clk);
        got_done = Done;
        if (Done) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL spurious_done: got Done=1 (Result %h), want no Done", Result);
            end else begin
                last_result = exp_q.pop_front();
                check(tag_q.pop_front(), Result, last_result);
            end
            if (prev_done) begin
                n_vec++; n_err++;
                $display("FAIL done_twice: got Done high two cycles, want one-cycle pulse");
            end
        end
        prev_done = Done;
    endtask

    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; Funct3 = f; SrcA = a; SrcB = b;
    endtask

    task automatic wait_done(input int exp_lat, input string name);
        int n;
        bit stall_ok;
        n = 0; stall_ok = 1'b1; got_done = 1'b0;
        while (!got_done && n < exp_lat + 8) begin
            cycle();
            n++;
            if (!got_done && !Stall) stall_ok = 1'b0;
        end
        if (!got_done) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: got no Done in %0d cycles, want Done after %0d", name, n, exp_lat);
        end else begin
            check({name, "_latency"}, 32'(n), 32'(exp_lat));
            check({name, "_stall_done"}, 32'(Stall), 32'd0);
            check({name, "_busy_done"}, 32'(Busy), 32'd1);
        end
        check({name, "_stall_held"}, 32'(stall_ok), 32'd1);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        drive(f, a, b);
        exp_q.push_back(exp);
        tag_q.push_back({name, "_result"});
        #1;
        check({name, "_stall_req"}, 32'(Stall), 32'd1);
        cycle();
        Start = 1'b0;
        wait_done(LAT, name);
        cycle();
        check({name, "_busy_idle"}, 32'(Busy), 32'd0);
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa, sb, q_s, r_s;
        sa = a; sb = b; q_s = 32'sd0; r_s = 32'sd0; p = '0;
        case (f)
            3'b000, 3'b001: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            3'b010:         p = {{32{a[31]}}, a} * {32'b0, b};
            3'b011:         p = {32'b0, a} * {32'b0, b};
            default:        p = '0;
        endcase
        if (b != 0 && !(a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
            q_s = sa / sb;
            r_s = sa % sb;
        end else if (b != 0) begin
            q_s = sa;
        end
        case (f)
            3'b000: return p[31:0];
            3'b001, 3'b010, 3'b011: return p[63:32];
            3'b100: if (b == 0) return 32'hFFFF_FFFF; else return q_s;
            3'b101: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
            3'b110: if (b == 0) return a; else return r_s;
            default: if (b == 0) return a; else return a % b;
        endcase
    endfunction

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        int          sel;
        clk = 1'b0; rst_n = 1'b0; Start = 1'b0; Kill = 1'b0;
        Funct3 = '0; SrcA = '0; SrcB = '0;
        n_vec = 0; n_err = 0; prev_done = 1'b0; got_done = 1'b0; last_result = '0;

        vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[3]  = '{3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000};
        vecs[4]  = '{3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD};
        vecs[5]  = '{3'b110, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001};
        vecs[6]  = '{3'b101, 32'd7,          32'hFFFF_FFFE, 32'h0000_0000};
        vecs[7]  = '{3'b111, 32'd7,          32'hFFFF_FFFE, 32'h0000_0007};
        vecs[8]  = '{3'b100, 32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[9]  = '{3'b110, 32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FF9C};
        vecs[10] = '{3'b101, 32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[11] = '{3'b111, 32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FF9C};
        vecs[12] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[13] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

        // Reset state, including combinational Stall on a request during reset.
        #12;
        check("reset_result", Result, 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_stall", 32'(Stall), 32'd0);
        Start = 1'b1;
        #1;
        check("reset_stall_start", 32'(Stall), 32'd1);
        Start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++)
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        for (int i = 0; i < 12; i++) begin
            rf  = 3'($urandom_range(7, 0));
            ra  = $urandom;
            sel = int'($urandom_range(3, 0));
            rb  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(16, 1)) : $urandom;
            run_op(rf, ra, rb, ref_model(rf, ra, rb), $sformatf("rnd%0d_f%0d", i, rf));
        end

        // Back-to-back: second request presented in DONE, accepted in the next IDLE.
        drive(3'b000, 32'd6, 32'd7);
        exp_q.push_back(32'd42); tag_q.push_back("b2b_first_result");
        cycle();
        Start = 1'b0;
        wait_done(LAT, "b2b_first");
        drive(3'b100, 32'd100, 32'd7);
        exp_q.push_back(32'd14); tag_q.push_back("b2b_second_result");
        #1;
        check("b2b_stall_in_done", 32'(Stall), 32'd0);
        cycle();
        check("b2b_stall_idle", 32'(Stall), 32'd1);
        check("b2b_busy_idle", 32'(Busy), 32'd0);
        cycle();
        Start = 1'b0;
        wait_done(LAT, "b2b_second");
        cycle();

        // Kill on the 10th CALC cycle, then an immediate new request.
        drive(3'b110, 32'd1000, 32'd7);
        cycle();
        Start = 1'b0;
        repeat (9) cycle();
        Kill = 1'b1;
        cycle();
        Kill = 1'b0;
        #1;
        check("kill_busy", 32'(Busy), 32'd0);
        check("kill_stall", 32'(Stall), 32'd0);
        check("kill_done", 32'(Done), 32'd0);
        check("kill_result_kept", Result, last_result);
        run_op(3'b101, 32'd1000, 32'd7, 32'd142, "after_kill");

        // Start together with Kill in IDLE is not accepted.
        drive(3'b000, 32'd3, 32'd5);
        Kill = 1'b1;
        #1;
        check("startkill_stall", 32'(Stall), 32'd0);
        cycle();
        Start = 1'b0; Kill = 1'b0;
        check("startkill_busy", 32'(Busy), 32'd0);
        repeat (40) cycle();
        check("startkill_busy_later", 32'(Busy), 32'd0);

        // Asynchronous reset in the middle of CALC.
        drive(3'b001, 32'h1234_5678, 32'h9ABC_DEF0);
        cycle();
        Start = 1'b0;
        repeat (5) cycle();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_done", 32'(Done), 32'd0);
        check("midrst_result", Result, 32'd0);
        check("midrst_stall", 32'(Stall), 32'd0);
        cycle();
        rst_n = 1'b1;
        repeat (40) cycle();
        check("midrst_busy_after", 32'(Busy), 32'd0);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
